// File: rtl/main_mem_burst.sv
// main_mem_burst: clocked main memory with programmable latency, byte-enabled
// writes and critical-word-first wrapping line bursts.
// Optional build macro: MAIN_MEM_PRELOAD_EN selects the paging-setup power-up image.
module main_mem_burst #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic              MEM_WE,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addressBus,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic [DATA_W-1:0] rdData,
  output logic              MEM_ACK,
  output logic              memLast,
  output logic              memErr,
  output logic              busy
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(BE_W);
  localparam int unsigned WIDX_W  = ADDR_W - OFF_W;
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_MAX = (LATENCY > LINE_WORDS) ? LATENCY : LINE_WORDS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // The array holds each word XOR its power-up image, so a zeroed array
  // reads back as the selected image without any initialisation logic.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              oor_q, oor_d;
  logic              we_q, we_d;
  logic              burst_q, burst_d;
  logic              ack_q, ack_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [WIDX_W-1:0] word_idx_c;
  logic [CNT_W-1:0]  nbeats_m1_c;
  logic              rd_sel_c;
  logic [CNT_W-1:0]  rd_beat_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [DATA_W-1:0] wr_img_c;
  logic              wr_en_c;

  // Power-up image of one word.
  function automatic logic [DATA_W-1:0] image(input logic [IDX_W-1:0] i);
`ifdef MAIN_MEM_PRELOAD_EN
    logic [31:0] w;
    logic [31:0] v;
    w = 32'(i);
    v = 32'h0;
    if (w == 32'h400) v = 32'h0000_2001;
    else if (w >= 32'h800 && w <= 32'h80C) v = 32'h0000_3001 + ((w - 32'h800) << 12);
    else if (w >= 32'hC00) v = 32'h0000_000D;
    return DATA_W'(v);
`else
    logic unused_i;
    unused_i = ^i;
    return '0;
`endif
  endfunction

  // Beat k of a line access wraps inside the aligned line.
  function automatic logic [IDX_W-1:0] beat_idx(input logic [IDX_W-1:0] start,
                                                input logic [CNT_W-1:0] k);
    return (start & ~LINE_MASK) | ((start + IDX_W'(k)) & LINE_MASK);
  endfunction

  assign word_idx_c  = WIDX_W'(addressBus >> OFF_W);
  assign nbeats_m1_c = burst_q ? CNT_W'(LINE_WORDS - 1) : '0;
  assign rd_idx_c    = beat_idx(idx_q, rd_beat_c);
  assign wr_idx_c    = beat_idx(idx_q, cnt_q);
  assign wr_img_c    = image(wr_idx_c);
  assign wr_en_c     = rst_n && (state_q == S_XFER) && we_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    oor_d     = oor_q;
    we_d      = we_q;
    burst_d   = burst_q;
    ack_d     = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    rd_sel_c  = 1'b0;
    rd_beat_c = '0;
    case (state_q)
      S_IDLE: begin
        if (request) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          idx_d   = IDX_W'(word_idx_c);
          oor_d   = (word_idx_c >= WIDX_W'(DEPTH));
          we_d    = MEM_WE;
          burst_d = burst;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          cnt_d = '0;
          ack_d = 1'b1;
          if (oor_q) begin
            state_d = S_ERR;
            last_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = S_XFER;
            last_d   = (nbeats_m1_c == '0);
            rd_sel_c = !we_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == nbeats_m1_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          ack_d     = 1'b1;
          last_d    = ((cnt_q + CNT_W'(1)) == nbeats_m1_c);
          rd_sel_c  = !we_q;
          rd_beat_c = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    rd_data_d = rd_sel_c ? (mem_q[rd_idx_c] ^ image(rd_idx_c)) : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      ack_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      oor_q     <= oor_d;
      we_q      <= we_d;
      burst_q   <= burst_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Byte-enabled write at the edge closing each write beat; reset blocks it.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (byteEn[b]) mem_q[wr_idx_c][b*8 +: 8] <= wrData[b*8 +: 8] ^ wr_img_c[b*8 +: 8];
      end
    end
  end

  assign rdData  = rd_data_q;
  assign MEM_ACK = ack_q;
  assign memLast = last_q;
  assign memErr  = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_main_mem_burst.sv
// Self-checking bench for main_mem_burst: directed cases plus randomized traffic
// against a word-array reference model.
module tb_main_mem_burst;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 16384;
  localparam int unsigned LW    = 4;
  localparam int unsigned LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          request;
  logic          MEM_WE;
  logic          burst;
  logic [AW-1:0] addressBus;
  logic [DW-1:0] wrData;
  logic [3:0]    byteEn;
  logic [DW-1:0] rdData;
  logic          MEM_ACK;
  logic          memLast;
  logic          memErr;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  bit [31:0] model [DEPTH];
  bit [31:0] tx_data [LW];
  bit [3:0]  tx_be [LW];

  main_mem_burst #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .MEM_WE(MEM_WE), .burst(burst),
    .addressBus(addressBus), .wrData(wrData), .byteEn(byteEn), .rdData(rdData),
    .MEM_ACK(MEM_ACK), .memLast(memLast), .memErr(memErr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] power_up_word(input int unsigned w);
`ifdef MAIN_MEM_PRELOAD_EN
    if (w == 32'h400) return 32'h0000_2001;
    if (w >= 32'h800 && w <= 32'h80C) return 32'h0000_3001 + ((w - 32'h800) * 32'h1000);
    if (w >= 32'hC00) return 32'h0000_000D;
    return 32'h0;
`else
    return w * 0;
`endif
  endfunction

  // One transaction, started at the current time (expected to be in an IDLE cycle).
  // abort_beat >= 0 pulses reset during that write beat instead of writing it.
  task automatic txn(input bit we, input bit bst, input logic [31:0] addr, input int abort_beat);
    int unsigned widx;
    int unsigned base;
    int unsigned bidx;
    bit          oor;
    int          n;
    int          k;
    widx = addr / 4;
    oor  = (widx >= DEPTH);
    n    = oor ? 1 : (bst ? int'(LW) : 1);
    base = widx - (widx % LW);
    request    = 1'b1;
    MEM_WE     = we;
    burst      = bst;
    addressBus = addr;
    wrData     = $urandom;
    byteEn     = 4'($urandom);
    @(posedge clk);
    #1;
    request    = 1'b0;
    MEM_WE     = 1'($urandom);
    burst      = 1'($urandom);
    addressBus = $urandom;
    for (int i = 1; i <= int'(LAT) + n + 1; i++) begin
      @(negedge clk);
      request = 1'($urandom);
      if (i <= int'(LAT)) begin
        chk("wait_ack", MEM_ACK, 0);
        chk("wait_busy", busy, 1);
      end else if (i <= int'(LAT) + n) begin
        k = i - int'(LAT) - 1;
        chk("beat_ack", MEM_ACK, 1);
        chk("beat_last", memLast, (k == n - 1) ? 1 : 0);
        chk("beat_err", memErr, oor ? 1 : 0);
        chk("beat_busy", busy, 1);
        if (oor) begin
          chk("err_rdata", rdData, 0);
        end else begin
          bidx = bst ? base + (((widx % LW) + k) % LW) : widx;
          if (!we) begin
            chk("rd_data", rdData, model[bidx]);
          end else if (k == abort_beat) begin
            rst_n   = 1'b0;
            request = 1'b1;
            @(negedge clk);
            chk("abort_ack", MEM_ACK, 0);
            chk("abort_busy", busy, 0);
            chk("abort_last", memLast, 0);
            chk("abort_rdata", rdData, 0);
            rst_n   = 1'b1;
            request = 1'b0;
            return;
          end else begin
            wrData = tx_data[k];
            byteEn = tx_be[k];
            for (int b = 0; b < 4; b++)
              if (tx_be[k][b]) model[bidx][b*8 +: 8] = tx_data[k][b*8 +: 8];
          end
        end
      end else begin
        request = 1'b0;
        chk("idle_ack", MEM_ACK, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rdata", rdData, 0);
      end
    end
  endtask

  task automatic wr1(input logic [31:0] addr, input bit [31:0] d, input bit [3:0] be);
    tx_data[0] = d;
    tx_be[0]   = be;
    txn(1'b1, 1'b0, addr, -1);
  endtask

  initial begin
    for (int w = 0; w < int'(DEPTH); w++) model[w] = power_up_word(w);
    rst_n      = 1'b0;
    request    = 1'b1;
    MEM_WE     = 1'b0;
    burst      = 1'b0;
    addressBus = 32'h100;
    wrData     = '0;
    byteEn     = '0;

    // Reset held 3 cycles with request asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", MEM_ACK, 0);
      chk("rst_last", memLast, 0);
      chk("rst_err", memErr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdData, 0);
    end
    rst_n   = 1'b1;
    request = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

`ifdef MAIN_MEM_PRELOAD_EN
    txn(1'b0, 1'b0, 32'h1000, -1);
    txn(1'b0, 1'b0, 32'h2030, -1);
    txn(1'b0, 1'b0, 32'h3000, -1);
`endif

    // Single write then read back.
    wr1(32'h100, 32'hDEAD_BEEF, 4'hF);
    txn(1'b0, 1'b0, 32'h100, -1);

    // Byte enables over a known word.
    wr1(32'h104, 32'hAAAA_AAAA, 4'hF);
    wr1(32'h104, 32'h1122_3344, 4'h5);
    txn(1'b0, 1'b0, 32'h104, -1);

    // Wrapping burst read starting mid-line.
    for (int k = 0; k < int'(LW); k++) begin
      tx_data[k] = 32'hA0 + k;
      tx_be[k]   = 4'hF;
    end
    txn(1'b1, 1'b1, 32'h200, -1);
    txn(1'b0, 1'b1, 32'h208, -1);
    txn(1'b0, 1'b1, 32'h20B, -1);

    // Out-of-range burst read.
    txn(1'b0, 1'b1, 32'h0001_0000, -1);
    txn(1'b1, 1'b1, 32'hFFFF_FFFC, -1);

    // Burst write aborted by reset during beat 2.
    wr1(32'h308, 32'h5555_0308, 4'hF);
    wr1(32'h30C, 32'h5555_030C, 4'hF);
    for (int k = 0; k < int'(LW); k++) begin
      tx_data[k] = 32'hC0DE_0000 + k;
      tx_be[k]   = 4'hF;
    end
    txn(1'b1, 1'b1, 32'h300, 2);
    @(negedge clk);
    for (int k = 0; k < int'(LW); k++) txn(1'b0, 1'b0, 32'h300 + 4 * k, -1);

    // Randomized traffic, mostly back-to-back in a small window.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      for (int k = 0; k < int'(LW); k++) begin
        tx_data[k] = $urandom;
        tx_be[k]   = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0001_0000;
      else a = ($urandom_range(0, 127) * 4) + $urandom_range(0, 3);
      txn(1'($urandom), 1'($urandom), a, -1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
